// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory controller.
package instr_mem_pkg;

   localparam int unsigned DATA_W            = 32;
   localparam int unsigned BANK_W            = 3;
   localparam int unsigned ROM_WORDS_DEFAULT = 512;
   localparam int unsigned ROM_ADDR_WIDTH    = $clog2(ROM_WORDS_DEFAULT);

   typedef enum logic {
      REG_ROM = 1'b0,
      REG_RAM = 1'b1
   } region_e;

   // Metadata carried from grant to response; data is selected from it, never from live inputs.
   typedef struct packed {
      logic              err;
      logic              is_rom;
      logic [BANK_W-1:0] bank;
      logic              is_write;
   } resp_tag_t;

   // One response entry as queued towards the core.
   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] rdata;
   } resp_t;

   // Word-interleaved bank select; num_banks is a power of two.
   function automatic logic [BANK_W-1:0] bank_of(input logic [31:0] wa, input int unsigned num_banks);
      return BANK_W'(wa & (num_banks - 1));
   endfunction

endpackage

// File: rtl/boot_rom_wrap.sv
// Boot ROM wrapper with a registered read port; content is a fixed pattern of the word index.
module boot_rom_wrap #(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [31:0]       rdata
);

   // Registered ROM read.
   always_ff @(posedge clk) begin
      if (en) rdata <= {16'hB007, 16'(addr)};
   end

endmodule

// File: rtl/instr_mem_resp_fifo.sv
// Fall-through response FIFO; an empty FIFO passes a push straight to its head.
module instr_mem_resp_fifo
   import instr_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  resp_t                        push_data,
   input  logic                         rready,
   output logic                         rvalid,
   output resp_t                        head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   resp_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              empty;
   logic              pop;
   logic              pop_stored;
   logic              store;

   assign empty      = (count == '0);
   assign rvalid     = !empty || push;
   assign head       = empty ? push_data : mem[rd_ptr];
   assign pop        = rvalid && rready;
   assign pop_stored = pop && !empty;
   assign store      = push && !(empty && pop);

   // Entry storage, not reset: contents are qualified by count.
   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (store)      wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop_stored) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(store) - CNT_W'(pop_stored);
      end
   end

endmodule

// File: rtl/sp_ram_wrap.sv
// Single-port RAM bank with byte-enable writes and a registered read port.
module sp_ram_wrap #(
   parameter int unsigned WORDS  = 4096,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              bypass_en,
   output logic [31:0]       rdata
);

   logic [31:0] mem [WORDS];

   // Byte-masked write or registered read; bypass loops write data to the read port.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= bypass_en ? wdata : mem[addr];
         end
      end
   end

endmodule

// File: rtl/instr_mem_bank_ctrl.sv
// Instruction-memory controller: ROM/RAM decode, interleaved banks, credit-based req/gnt, in-order responses.
module instr_mem_bank_ctrl
   import instr_mem_pkg::*;
#(
   parameter int unsigned RAM_SIZE   = 32768,
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned ROM_WORDS  = 512,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   input  logic                  boot_lock_i,
   input  logic                  bypass_en_i
);

   localparam int unsigned WA_W       = ADDR_WIDTH - 3;
   localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
   localparam int unsigned BANK_WORDS = RAM_SIZE / 4 / NUM_BANKS;
   localparam int unsigned BANK_AW    = $clog2(BANK_WORDS);
   localparam int unsigned ROM_AW     = $clog2(ROM_WORDS);
   localparam int unsigned DEPTH      = RD_LATENCY + 1;
   localparam int unsigned CNT_W      = $clog2(DEPTH + 1);

   logic [WA_W-1:0]    wa;
   region_e            region;
   logic               rom_err;
   logic [BANK_W-1:0]  bank_sel;
   logic [BANK_AW-1:0] bank_idx;
   logic [ROM_AW-1:0]  rom_idx;
   logic [NUM_BANKS-1:0] bank_en;
   logic               rom_en;
   logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];
   logic [DATA_W-1:0]  rom_rdata;
   logic [DATA_W-1:0]  mem_data;
   resp_tag_t          tag_d;
   resp_tag_t          s1_tag;
   logic               s1_valid;
   resp_t              s1_resp;
   logic               push;
   resp_t              push_data;
   logic [1:0]         occ;
   logic [CNT_W-1:0]   fifo_cnt;
   logic               credit_ok;
   logic               fifo_rvalid;
   resp_t              fifo_head;
   logic               unused_addr;

   assign unused_addr = ^addr_i[1:0];

   // Address decode.
   assign wa       = addr_i[ADDR_WIDTH-2:2];
   assign region   = region_e'(addr_i[ADDR_WIDTH-1]);
   assign bank_sel = bank_of(32'(wa), NUM_BANKS);
   assign bank_idx = BANK_AW'(wa >> BANK_BITS);
   assign rom_idx  = ROM_AW'(wa);
   assign rom_err  = (region == REG_ROM) && (we_i || (32'(wa) >= ROM_WORDS) || boot_lock_i);

   // Credits come from registered occupancy only, so a pop frees a slot one cycle later.
   assign credit_ok = (32'(occ) + 32'(fifo_cnt)) < DEPTH;
   assign gnt_o     = req_i && credit_ok && !rst;

   // Enable exactly one memory per granted, non-error access.
   always_comb begin
      rom_en  = 1'b0;
      bank_en = '0;
      if (gnt_o) begin
         if (region == REG_ROM) begin
            rom_en = !rom_err;
         end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
               if (32'(bank_sel) == b) bank_en[b] = 1'b1;
            end
         end
      end
   end

   // Tag captured at grant.
   always_comb begin
      tag_d          = '0;
      tag_d.err      = rom_err;
      tag_d.is_rom   = (region == REG_ROM);
      tag_d.bank     = bank_sel;
      tag_d.is_write = we_i;
   end

   // First pipeline stage: aligned with memory read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
      end else begin
         s1_valid <= gnt_o;
         if (gnt_o) s1_tag <= tag_d;
      end
   end

   // Response data chosen by the tag; writes and errors return zero.
   always_comb begin
      s1_resp  = '0;
      mem_data = rom_rdata;
      if (!s1_tag.is_rom) begin
         mem_data = '0;
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (32'(s1_tag.bank) == b) mem_data = bank_rdata[b];
         end
      end
      s1_resp.err   = s1_tag.err;
      s1_resp.rdata = (s1_tag.err || s1_tag.is_write) ? '0 : mem_data;
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic  s2_valid;
         resp_t s2_resp;

         // Extra output register stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_valid <= 1'b0;
               s2_resp  <= '0;
            end else begin
               s2_valid <= s1_valid;
               s2_resp  <= s1_resp;
            end
         end

         assign push      = s2_valid;
         assign push_data = s2_resp;
         assign occ       = {1'b0, s1_valid} + {1'b0, s2_valid};
      end else begin : g_lat1
         assign push      = s1_valid;
         assign push_data = s1_resp;
         assign occ       = {1'b0, s1_valid};
      end
   endgenerate

   instr_mem_resp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .rready    (rready_i),
      .rvalid    (fifo_rvalid),
      .head      (fifo_head),
      .count     (fifo_cnt)
   );

   assign rvalid_o = fifo_rvalid;
   assign rdata_o  = fifo_rvalid ? fifo_head.rdata : '0;
   assign err_o    = fifo_rvalid && fifo_head.err;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      sp_ram_wrap #(
         .WORDS  (BANK_WORDS),
         .ADDR_W (BANK_AW)
      ) u_bank (
         .clk       (clk),
         .en        (bank_en[b]),
         .we        (we_i),
         .be        (be_i),
         .addr      (bank_idx),
         .wdata     (wdata_i),
         .bypass_en (bypass_en_i),
         .rdata     (bank_rdata[b])
      );
   end

   boot_rom_wrap #(
      .ADDR_W (ROM_AW)
   ) u_rom (
      .clk   (clk),
      .en    (rom_en),
      .addr  (rom_idx),
      .rdata (rom_rdata)
   );

endmodule

// File: tb/tb_instr_mem_bank_ctrl.sv
// Bench for instr_mem_bank_ctrl: latency-1 and latency-2 instances share stimulus, each checked against a transaction model.
module tb_instr_mem_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst, req, we, rready, boot_lock, bypass_en;
   logic [15:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt    [2];
   logic        rvalid [2];
   logic        err    [2];
   logic [31:0] rdata  [2];

   always #5 clk = ~clk;

   instr_mem_bank_ctrl #(.RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt[0]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rready_i(rready),
      .rdata_o(rdata[0]), .err_o(err[0]), .boot_lock_i(boot_lock), .bypass_en_i(bypass_en)
   );

   instr_mem_bank_ctrl #(.RD_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt[1]), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rready_i(rready),
      .rdata_o(rdata[1]), .err_o(err[1]), .boot_lock_i(boot_lock), .bypass_en_i(bypass_en)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rom_word(input int wa);
      return {16'hB007, 16'(wa)};
   endfunction

   // Model state: RAM image, outstanding-response queue per instance, logs of pops and grants.
   logic [31:0] mram  [2][8192];
   int          qcnt  [2];
   int          qhead [2];
   logic        qerr  [2][8];
   logic [31:0] qdata [2][8];
   int          qtime [2][8];
   int          cyc = 0;
   int          gnt_cnt  [2];
   int          pop_cnt  [2];
   int          last_gnt_cyc [2];
   logic [31:0] plog_d [2][256];
   logic        plog_e [2][256];
   int          plog_c [2][256];

   initial begin
      for (int i = 0; i < 2; i++) begin
         qcnt[i] = 0; qhead[i] = 0; gnt_cnt[i] = 0; pop_cnt[i] = 0; last_gnt_cyc[i] = 0;
      end
   end

   // Compare process: every cycle, derive expected outputs from the outstanding-response model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int lat, wa, slot;
         bit eg, ev, pop, e;
         logic [31:0] d;
         if (rst) begin
            qcnt[i]  = 0;
            qhead[i] = 0;
            chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 0);
            chk($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 0);
            chk($sformatf("rst_err%0d", i), 32'(err[i]), 0);
         end else begin
            lat = i + 1;
            eg  = req && (qcnt[i] < lat + 1);
            ev  = (qcnt[i] > 0) && (qtime[i][qhead[i]] <= cyc);
            chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(eg));
            chk($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(ev));
            if (ev) begin
               chk($sformatf("rdata%0d", i), rdata[i], qdata[i][qhead[i]]);
               chk($sformatf("err%0d", i), 32'(err[i]), 32'(qerr[i][qhead[i]]));
            end
            pop = ev && rready;
            if (pop) begin
               plog_d[i][pop_cnt[i] & 255] = qdata[i][qhead[i]];
               plog_e[i][pop_cnt[i] & 255] = qerr[i][qhead[i]];
               plog_c[i][pop_cnt[i] & 255] = cyc;
               pop_cnt[i]++;
               qhead[i] = (qhead[i] + 1) % 8;
               qcnt[i]--;
            end
            if (eg) begin
               wa = int'(addr[14:2]);
               if (addr[15] == 1'b0) begin
                  e = we || (wa >= 512) || boot_lock;
                  d = e ? 32'h0 : rom_word(wa);
               end else begin
                  e = 1'b0;
                  d = we ? 32'h0 : mram[i][wa];
                  if (we) begin
                     for (int b = 0; b < 4; b++) begin
                        if (be[b]) mram[i][wa][8*b +: 8] = wdata[8*b +: 8];
                     end
                  end
               end
               slot = (qhead[i] + qcnt[i]) % 8;
               qerr[i][slot]  = e;
               qdata[i][slot] = d;
               qtime[i][slot] = cyc + lat;
               qcnt[i]++;
               gnt_cnt[i]++;
               last_gnt_cyc[i] = cyc;
            end
         end
      end
      cyc++;
   end

   function automatic logic [31:0] last_d(input int i, input int back);
      return plog_d[i][(pop_cnt[i] - back) & 255];
   endfunction

   function automatic logic last_e(input int i, input int back);
      return plog_e[i][(pop_cnt[i] - back) & 255];
   endfunction

   function automatic int last_c(input int i, input int back);
      return plog_c[i][(pop_cnt[i] - back) & 255];
   endfunction

   // One-cycle request; entered and left at posedge+1.
   task automatic drive(input logic [15:0] a, input logic w, input logic [3:0] b, input logic [31:0] dt);
      req = 1'b1; addr = a; we = w; be = b; wdata = dt;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      req = 1'b0; we = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   int pc0, pc1, gc0, gc1, g0, g1;

   initial begin
      rst = 1'b1; req = 1'b1; addr = '0; we = 1'b0; be = '0; wdata = '0;
      rready = 1'b1; boot_lock = 1'b0; bypass_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; req = 1'b0;
      idle(1);

      // ROM word 0 read: latency 1 and 2.
      pc0 = pop_cnt[0]; pc1 = pop_cnt[1];
      drive(16'h0000, 1'b0, 4'h0, 32'h0);
      idle(4);
      chk("t1_pops0", 32'(pop_cnt[0] - pc0), 1);
      chk("t1_pops1", 32'(pop_cnt[1] - pc1), 1);
      chk("t1_data0", last_d(0, 1), 32'hB007_0000);
      chk("t1_err0", 32'(last_e(0, 1)), 0);
      chk("t1_lat0", 32'(last_c(0, 1) - last_gnt_cyc[0]), 1);
      chk("t1_lat1", 32'(last_c(1, 1) - last_gnt_cyc[1]), 2);

      // Fill 16 RAM words back to back.
      gc0 = gnt_cnt[0]; gc1 = gnt_cnt[1]; pc0 = pop_cnt[0]; pc1 = pop_cnt[1];
      for (int k = 0; k < 16; k++) drive(16'h8000 | 16'(k << 2), 1'b1, 4'hF, 32'hA000_0000 | 32'(k));
      idle(4);
      chk("t2_gnts0", 32'(gnt_cnt[0] - gc0), 16);
      chk("t2_gnts1", 32'(gnt_cnt[1] - gc1), 16);
      chk("t2_pops0", 32'(pop_cnt[0] - pc0), 16);
      chk("t2_pops1", 32'(pop_cnt[1] - pc1), 16);

      // Partial write then read-back in the next cycle.
      drive(16'h8004, 1'b1, 4'hF, 32'h1122_3344);
      drive(16'h8004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      drive(16'h8004, 1'b0, 4'h0, 32'h0);
      idle(4);
      chk("t3_data0", last_d(0, 1), 32'h1122_BEEF);
      chk("t3_data1", last_d(1, 1), 32'h1122_BEEF);

      // ROM write, out-of-range ROM read, boot-locked ROM read.
      drive(16'h0010, 1'b1, 4'hF, 32'h1234_5678);
      drive(16'h0800, 1'b0, 4'h0, 32'h0);
      boot_lock = 1'b1;
      drive(16'h0000, 1'b0, 4'h0, 32'h0);
      boot_lock = 1'b0;
      idle(4);
      for (int b = 1; b <= 3; b++) begin
         chk($sformatf("t4_err0_%0d", b), 32'(last_e(0, b)), 1);
         chk($sformatf("t4_data0_%0d", b), last_d(0, b), 0);
         chk($sformatf("t4_err1_%0d", b), 32'(last_e(1, b)), 1);
      end

      // Back-to-back reads across both banks.
      pc0 = pop_cnt[0];
      for (int k = 0; k < 4; k++) drive(16'h8000 | 16'(k << 2), 1'b0, 4'h0, 32'h0);
      idle(4);
      chk("t5_pops0", 32'(pop_cnt[0] - pc0), 4);
      chk("t5_d0", last_d(0, 4), 32'hA000_0000);
      chk("t5_d1", last_d(0, 3), 32'h1122_BEEF);
      chk("t5_d2", last_d(0, 2), 32'hA000_0002);
      chk("t5_d3", last_d(0, 1), 32'hA000_0003);
      chk("t5_consec", 32'(last_c(0, 1) - last_c(0, 4)), 3);

      // Backpressure: grants stop at the credit limit, resume a cycle after the first pop.
      rready = 1'b0;
      gc0 = gnt_cnt[0]; gc1 = gnt_cnt[1];
      req = 1'b1; addr = 16'h8008; we = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      chk("t6_full0", 32'(gnt_cnt[0] - gc0), 2);
      chk("t6_full1", 32'(gnt_cnt[1] - gc1), 3);
      rready = 1'b1;
      g0 = gnt_cnt[0]; g1 = gnt_cnt[1]; pc1 = pop_cnt[1];
      @(negedge clk); #1;
      chk("t6_pop1", 32'(pop_cnt[1] - pc1), 1);
      chk("t6_nognt0", 32'(gnt_cnt[0] - g0), 0);
      chk("t6_nognt1", 32'(gnt_cnt[1] - g1), 0);
      @(negedge clk); #1;
      chk("t6_regnt0", 32'(gnt_cnt[0] - g0), 1);
      chk("t6_regnt1", 32'(gnt_cnt[1] - g1), 1);
      @(posedge clk); #1;
      idle(6);
      chk("t6_data1", last_d(1, 1), 32'hA000_0002);

      // Reset with responses queued.
      rready = 1'b0;
      drive(16'h8000, 1'b0, 4'h0, 32'h0);
      drive(16'h8008, 1'b0, 4'h0, 32'h0);
      idle(3);
      chk("t7_pending0", 32'(rvalid[0]), 1);
      chk("t7_pending1", 32'(rvalid[1]), 1);
      rst = 1'b1;
      #1;
      chk("t7_rst_rv0", 32'(rvalid[0]), 0);
      chk("t7_rst_rv1", 32'(rvalid[1]), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; rready = 1'b1;
      pc0 = pop_cnt[0]; pc1 = pop_cnt[1];
      drive(16'h800C, 1'b0, 4'h0, 32'h0);
      idle(5);
      chk("t7_pops0", 32'(pop_cnt[0] - pc0), 1);
      chk("t7_pops1", 32'(pop_cnt[1] - pc1), 1);
      chk("t7_data0", last_d(0, 1), 32'hA000_0003);
      chk("t7_data1", last_d(1, 1), 32'hA000_0003);

      // Randomized traffic with backpressure, boot lock and occasional reset.
      for (int n = 0; n < 3000; n++) begin
         req    = ($urandom_range(0, 3) != 0);
         we     = ($urandom_range(0, 3) == 0);
         be     = 4'($urandom_range(0, 15));
         wdata  = $urandom;
         rready = ($urandom_range(0, 3) != 0);
         boot_lock = ($urandom_range(0, 15) == 0);
         rst    = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 1) == 0)
            addr = 16'($urandom_range(0, 16'h0FFF));
         else
            addr = 16'h8000 | 16'($urandom_range(0, 15) << 2) | 16'($urandom_range(0, 3));
         @(posedge clk); #1;
      end
      rst = 1'b0; rready = 1'b1; boot_lock = 1'b0;
      idle(8);
      chk("drain_rv0", 32'(rvalid[0]), 0);
      chk("drain_rv1", 32'(rvalid[1]), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_bank_ctrl.md
# instr_mem_bank_ctrl

Parametrised instruction-memory controller for the core's instruction port. It decodes each request into a boot-ROM region or a RAM region. RAM words are interleaved across NUM_BANKS single-port banks. Requests use a req/gnt handshake and responses use an rvalid/rready channel with backpressure, so the controller replaces the fixed-latency, handshake-less instruction RAM wrapper. It also adds a boot-lock mode and error responses for illegal accesses.

## Interface

Parameters:
- RAM_SIZE, 32768: RAM region size in bytes; power of two.
- NUM_BANKS, 2: number of word-interleaved RAM banks; power of two, 1..8; each bank is RAM_SIZE/NUM_BANKS bytes.
- ROM_WORDS, 512: populated boot-ROM words; power of two.
- RD_LATENCY, 1: grant-to-data latency; 1 (memory output direct) or 2 (extra output register).
- ADDR_WIDTH, $clog2(RAM_SIZE)+1: byte address width; the MSB selects the region.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst, in, 1: asynchronous, active-high reset.
- req_i, in, 1: request valid.
- gnt_o, out, 1: request accepted this cycle (combinational from req_i and the credit state).
- addr_i, in, ADDR_WIDTH: byte address; bits [1:0] are ignored.
- we_i, in, 1: write request.
- be_i, in, 4: byte enables for writes.
- wdata_i, in, 32: write data.
- rvalid_o, out, 1: response valid.
- rready_i, in, 1: response consumed when rvalid_o && rready_i.
- rdata_o, out, 32: read data; 0 for write or error responses.
- err_o, out, 1: error flag qualifying the response.
- boot_lock_i, in, 1: while high, every ROM-region access is an error.
- bypass_en_i, in, 1: passed to all RAM banks unchanged.

## Operation

- Region decode:
  - addr_i[ADDR_WIDTH-1]==0 selects ROM; ==1 selects RAM.
  - Word address wa = addr_i[ADDR_WIDTH-2:2].
  - RAM bank = wa mod NUM_BANKS; in-bank index = wa / NUM_BANKS.
- A ROM access is an error when any of the following holds: we_i is 1, wa >= ROM_WORDS, or boot_lock_i is 1 (sampled at grant). Error accesses enable no memory.
- At a grant:
  - Exactly one memory is enabled: the selected bank or the ROM.
  - A tag {err, is_rom, bank, is_write} travels down a RD_LATENCY-deep valid/tag pipeline.
- Every grant produces exactly one response, in order, including writes and errors.
- Response FIFO: depth RD_LATENCY+1, fall-through. Its head drives rvalid_o, rdata_o and err_o.
- Credits:
  - credits = (RD_LATENCY+1) − (pipeline occupancy + FIFO count).
  - gnt_o = req_i && credits>0 && !rst.
  - A pop in the current cycle does not create a credit until the next cycle.
- rdata selection uses the tag's is_rom/bank; never use the live addr_i.
- The response FIFO is the only storage holding memory read data across a stall, so rready_i low never loses data.
- Reset mid-operation:
  - All in-flight and queued responses are discarded.
  - Memory contents are untouched.
  - Writes granted before reset are committed only if the memory clock edge occurred.

## Timing

- Reset values: gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, pipeline empty, FIFO empty, credits RD_LATENCY+1.
- Response latency:
  - A grant in cycle G with an empty FIFO gives rvalid_o high in cycle G+RD_LATENCY, combinationally from the pipeline output through the FIFO bypass.
  - If the FIFO is non-empty, the response appears after all older responses have been popped.
- Throughput: with rready_i held high, one grant and one response per cycle, sustained indefinitely.
- Full condition: with rready_i low, at most RD_LATENCY+1 grants are accepted, then gnt_o stays 0 until a pop occurs.
- Simultaneous push and pop on a full FIFO is legal because credits already prevent overflow.
- Simultaneous push and pop on an empty FIFO is the bypass case: the data passes straight through, no entry is stored.
- Write data and byte enables are applied to the bank in the grant cycle.
- A read of the same word in the next cycle returns the new data.

## Structure

- Package instr_mem_pkg holds:
  - region_e {REG_ROM, REG_RAM};
  - the resp_tag_t struct;
  - the function bank_of(wa, NUM_BANKS);
  - ROM_ADDR_WIDTH = $clog2(ROM_WORDS).
- Sub-module instr_mem_resp_fifo: parametrised depth, fall-through, holding {err, rdata}.
- Banks instantiate the existing sp_ram_wrap, NUM_BANKS times in a generate loop. The ROM instantiates boot_rom_wrap.

## Test plan

- Reset, then read 0x0000 with RD_LATENCY=1 -> rvalid_o at G+1, rdata_o = ROM word 0, err_o 0.
- Write 0xDEADBEEF with be_i=4'b0011 to 0x8004, then read 0x8004 -> rdata_o = old[31:16]:BEEF, served by bank 1 (NUM_BANKS=2).
- Write to 0x0010, read 0x0800 (ROM_WORDS=512), and read ROM with boot_lock_i=1 -> three responses, each err_o=1 and rdata_o=0.
- RD_LATENCY=2, rready_i=0, req_i held -> exactly 3 grants. Then raise rready_i -> responses in order, and gnt_o re-asserts the cycle after the first pop.
- Back-to-back reads of 0x8000, 0x8004, 0x8008, 0x800C with rready_i=1 -> 4 consecutive rvalid_o cycles, bank order 0,1,0,1.
- Assert rst with 2 responses queued -> rvalid_o 0 immediately. After release, a new read returns correct data with no stale response.
